// File: rtl/sonar_pkg.sv
// sonar_pkg: shared state encoding, default timing and data width for the sonar ranger
package sonar_pkg;
  typedef enum logic [2:0] {S_IDLE, S_TRIG, S_WAIT_RISE, S_ECHO, S_DONE, S_HOLDOFF} state_e;
  localparam int unsigned DIST_W           = 32;
  localparam int unsigned DEF_TRIG_CYC     = 500;
  localparam int unsigned DEF_CYC_PER_UNIT = 291;
  localparam int unsigned DEF_RISE_TO_CYC  = 50000;
  localparam int unsigned DEF_ECHO_TO_CYC  = 1900000;
  localparam int unsigned DEF_HOLDOFF_CYC  = 3000000;
endpackage

// File: rtl/sonar_sync.sv
// sonar_sync: two-flop synchronizer for the echo pin with rise/fall pulses on the synchronized level
module sonar_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_echo,
  output logic o_rise,
  output logic o_fall
);
  logic r_meta, r_sync, r_prev;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {r_meta, r_sync, r_prev} <= '0;
    else        {r_meta, r_sync, r_prev} <= {i_echo, r_meta, r_sync};
  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;
endmodule

// File: rtl/sonar_ranger.sv
// sonar_ranger: ultrasonic trigger/echo ranging FSM; define SONAR_AVG_EN for a 4-result mean distance
module sonar_ranger
  import sonar_pkg::*;
#(
  parameter int unsigned TRIG_CYC     = DEF_TRIG_CYC,
  parameter int unsigned CYC_PER_UNIT = DEF_CYC_PER_UNIT,
  parameter int unsigned RISE_TO_CYC  = DEF_RISE_TO_CYC,
  parameter int unsigned ECHO_TO_CYC  = DEF_ECHO_TO_CYC,
  parameter int unsigned HOLDOFF_CYC  = DEF_HOLDOFF_CYC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trigger,
  output logic              triggerSuc,
  output logic              valid,
  output logic [DIST_W-1:0] distance,
  output logic              timeout_err,
  output logic              sr_trig,
  input  logic              sr_echo
);
  state_e r_state, w_nxt;
  logic [DIST_W-1:0] r_cnt, w_cnt_n, r_pre, w_pre_n, r_acc, w_acc_n, w_acc_inc, w_res, r_dist;
  logic r_trig, w_trig_n, r_suc, w_suc_n, r_valid, r_to, w_ok, w_to, w_rise, w_fall, w_wrap;

  sonar_sync u_sync (.clk(clk), .rst_n(rst_n), .i_echo(sr_echo), .o_rise(w_rise), .o_fall(w_fall));

  assign w_wrap    = r_pre == CYC_PER_UNIT - 1;
  assign w_acc_inc = (w_wrap && r_acc != '1) ? r_acc + 1'b1 : r_acc;

  always_comb begin
    w_nxt    = r_state;
    w_cnt_n  = r_cnt + 1'b1;
    w_pre_n  = r_pre;
    w_acc_n  = r_acc;
    w_trig_n = 1'b0;
    w_suc_n  = 1'b0;
    w_ok     = 1'b0;
    w_to     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_n = '0;
        if (trigger) begin
          w_nxt    = S_TRIG;
          w_trig_n = 1'b1;
        end
      end
      S_TRIG:
        if (r_cnt == TRIG_CYC - 1) begin
          w_nxt   = S_WAIT_RISE;
          w_cnt_n = '0;
          w_suc_n = 1'b1;
        end else w_trig_n = 1'b1;
      S_WAIT_RISE:
        if (w_rise) begin
          w_nxt   = S_ECHO;
          w_cnt_n = '0;
          w_pre_n = '0;
          w_acc_n = '0;
        end else if (r_cnt == RISE_TO_CYC - 1) begin
          w_nxt = S_DONE;
          w_to  = 1'b1;
        end
      S_ECHO: begin
        w_pre_n = w_wrap ? '0 : r_pre + 1'b1;
        w_acc_n = w_acc_inc;
        if (w_fall) begin
          w_nxt = S_DONE;
          w_ok  = 1'b1;
        end else if (r_cnt == ECHO_TO_CYC - 1) begin
          w_nxt = S_DONE;
          w_to  = 1'b1;
        end
      end
      S_DONE: begin
        w_nxt   = S_HOLDOFF;
        w_cnt_n = '0;
      end
      S_HOLDOFF:
        if (r_cnt == HOLDOFF_CYC - 1) begin
          w_nxt   = S_IDLE;
          w_cnt_n = '0;
        end
      default: w_nxt = S_IDLE;
    endcase
  end

`ifdef SONAR_AVG_EN
  localparam int unsigned SUM_W = DIST_W + 2;
  logic [DIST_W-1:0] r_win [3];
  logic              r_have;
  logic [SUM_W-1:0]  w_sum;
  assign w_sum = r_have ? SUM_W'(w_acc_inc) + SUM_W'(r_win[0]) + SUM_W'(r_win[1]) + SUM_W'(r_win[2])
                        : {w_acc_inc, 2'b00};
  assign w_res = w_sum[SUM_W-1:2];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_have <= 1'b0;
      r_win  <= '{default: '0};
    end else if (w_ok) begin
      r_have   <= 1'b1;
      r_win[0] <= w_acc_inc;
      r_win[1] <= r_have ? r_win[0] : w_acc_inc;
      r_win[2] <= r_have ? r_win[1] : w_acc_inc;
    end
`else
  assign w_res = w_acc_inc;
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_pre   <= '0;
      r_acc   <= '0;
      r_trig  <= 1'b0;
      r_suc   <= 1'b0;
      r_valid <= 1'b0;
      r_to    <= 1'b0;
      r_dist  <= '0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= w_cnt_n;
      r_pre   <= w_pre_n;
      r_acc   <= w_acc_n;
      r_trig  <= w_trig_n;
      r_suc   <= w_suc_n;
      r_valid <= w_ok | w_to;
      r_to    <= w_to;
      if (w_ok) r_dist <= w_res;
    end

  assign sr_trig     = r_trig;
  assign triggerSuc  = r_suc;
  assign valid       = r_valid;
  assign timeout_err = r_to;
  assign distance    = r_dist;
endmodule

// File: tb/tb_sonar_ranger.sv
// tb_sonar_ranger: randomized echo timing against a duration-level reference model of the ranger
module tb_sonar_ranger;
  localparam int TC = 10, CU = 4, RT = 100, ET = 200, HO = 50;
  logic clk = 1'b0, rst_n = 1'b0, trigger = 1'b0, sr_echo = 1'b0;
  logic triggerSuc, valid, timeout_err, sr_trig;
  logic [31:0] distance;
  int n_cmp = 0, n_err = 0;
  int unsigned hist[$];

  always #5 clk = ~clk;

  sonar_ranger #(.TRIG_CYC(TC), .CYC_PER_UNIT(CU), .RISE_TO_CYC(RT), .ECHO_TO_CYC(ET), .HOLDOFF_CYC(HO)) dut (
    .clk(clk), .rst_n(rst_n), .trigger(trigger), .triggerSuc(triggerSuc), .valid(valid),
    .distance(distance), .timeout_err(timeout_err), .sr_trig(sr_trig), .sr_echo(sr_echo)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_dist();
    longint unsigned s = 0;
    int n = hist.size();
    if (n == 0) return 32'd0;
`ifdef SONAR_AVG_EN
    for (int i = 0; i < 4; i++) s += (n - 1 - i >= 0) ? longint'(hist[n-1-i]) : longint'(hist[0]);
    return 32'(s / 4);
`else
    s = longint'(hist[n-1]);
    return 32'(s);
`endif
  endfunction

  // k: cycles after the triggerSuc sample at which echo rises; n: echo high length
  task automatic measure(input string tag, input int k, input int n, input bit rise, input bit stuck, input bit hold);
    int t, len, suc, nv, stray, tv, t_exp;
    bit ok, to_exp;
    logic to_got;
    logic [31:0] d_got;
    trigger = 1'b1;
    t = 0;
    while (!sr_trig && t < 300) begin t++; tick; end
    chk({tag, ":trig_seen"}, 32'(sr_trig), 1);
    len = 0; suc = 0;
    while (sr_trig && len < 50) begin
      len++;
      if (triggerSuc) suc++;
      tick;
    end
    chk({tag, ":trig_len"}, 32'(len), TC);
    chk({tag, ":suc_early"}, 32'(suc), 0);
    chk({tag, ":suc_on_fall"}, 32'(triggerSuc), 1);
    if (!hold) trigger = 1'b0;
    ok     = rise && (k + 2 <= RT - 1);
    to_exp = !ok || stuck || n > ET;
    t_exp  = !ok ? RT : (stuck || n > ET) ? k + ET + 3 : k + n + 3;
    if (!to_exp) hist.push_back(n / CU);
    t = 0; nv = 0; stray = 0; tv = -1; to_got = 1'b0; d_got = '0;
    while (t < 1000) begin
      if (valid) begin
        nv++;
        if (tv < 0) begin tv = t; to_got = timeout_err; d_got = distance; end
      end
      if (timeout_err && !valid) stray++;
      if (rise && t == k) sr_echo = 1'b1;
      if (rise && !stuck && t == k + n) sr_echo = 1'b0;
      if (tv >= 0 && t > tv && (!rise || stuck || t >= k + n)) break;
      tick;
      t++;
    end
    chk({tag, ":valid_time"}, 32'(tv), 32'(t_exp));
    chk({tag, ":valid_width"}, 32'(nv), 1);
    chk({tag, ":timeout_err"}, 32'(to_got), 32'(to_exp));
    chk({tag, ":stray_to"}, 32'(stray), 0);
    chk({tag, ":distance"}, d_got, model_dist());
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int act, t;
    repeat (3) tick;
    chk("rst_dist", distance, 0);
    chk("rst_ctl", 32'({triggerSuc, valid, timeout_err, sr_trig}), 0);
    rst_n = 1'b1;
    act = 0;
    repeat (100) begin
      tick;
      if (sr_trig || valid || triggerSuc || timeout_err) act++;
    end
    chk("idle_quiet", 32'(act), 0);

    measure("norm", 5, 41, 1, 0, 0);
    measure("noecho", 0, 0, 0, 0, 0);
    measure("stuck", 10, 0, 1, 1, 0);
    measure("prehigh", 0, 0, 0, 0, 0);
    sr_echo = 1'b0;
    measure("rise_last", 97, 8, 1, 0, 0);
    measure("rise_late", 98, 8, 1, 0, 0);
    measure("echo_max", 3, 200, 1, 0, 0);
    measure("echo_over", 3, 201, 1, 0, 0);

    measure("hold", 4, 20, 1, 0, 1);
    t = 0;
    while (!sr_trig && t < 300) begin t++; tick; end
    chk("holdoff_gap", 32'(t), HO + 1);
    measure("hold2", 6, 33, 1, 0, 0);

    trigger = 1'b1;
    t = 0;
    while (!sr_trig && t < 300) begin t++; tick; end
    repeat (3) tick;
    #2 rst_n = 1'b0;
    hist.delete();
    #1 chk("rst_mid_trig", 32'(sr_trig), 0);
    trigger = 1'b0;
    tick;
    rst_n = 1'b1;
    trigger = 1'b1;
    t = 0;
    while (!triggerSuc && t < 300) begin t++; tick; end
    trigger = 1'b0;
    sr_echo = 1'b1;
    repeat (30) tick;
    #2 rst_n = 1'b0;
    #1 chk("rst_mid_echo_dist", distance, 0);
    chk("rst_mid_echo_ctl", 32'({triggerSuc, valid, timeout_err, sr_trig}), 0);
    sr_echo = 1'b0;
    repeat (3) tick;
    rst_n = 1'b1;

    measure("avg1", 2, 41, 1, 0, 0);
    measure("avg2", 7, 80, 1, 0, 0);
    measure("avg3", 1, 120, 1, 0, 0);
    measure("avg4", 9, 160, 1, 0, 0);

    for (int i = 0; i < 12; i++)
      measure($sformatf("rnd%0d", i), int'($urandom_range(0, 99)), int'($urandom_range(1, 230)),
              $urandom_range(0, 9) != 0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
